// File: rtl/elevator_pkg.sv
// Shared types and default parameters for the elevator car controller.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 4;
  localparam int FLOOR_W_DEF    = 2;
  localparam int CNT_W          = 28;
  localparam int BLANK_CYCLES   = 2;

  localparam logic [CNT_W-1:0] TRAVEL_TICKS_DEF = 28'd50_000_000;
  localparam logic [CNT_W-1:0] DOOR_TICKS_DEF   = 28'd150_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_MOVE = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

endpackage

// File: rtl/elevator_car_fsm_timer_event_qual.sv
// Qualifies the external counter's finished level into single-cycle events:
// rising edge only, masked for a short blanking window after run rises and after each event.
module timer_event_qual
  import elevator_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic finished,
  output logic evt
);

  logic       fin_prev;
  logic [1:0] blank_cnt;

  assign evt = run && finished && !fin_prev && (blank_cnt == 2'd0);

  // Blanking reloads whenever the counter is idle, so it is already armed when run rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_prev  <= 1'b0;
      blank_cnt <= 2'(BLANK_CYCLES);
    end else begin
      fin_prev <= finished;
      if (!run || evt)
        blank_cnt <= 2'(BLANK_CYCLES);
      else if (blank_cnt != 2'd0)
        blank_cnt <= blank_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/elevator_car_fsm.sv
// Car-motion controller: accepts one target floor at a time, steps the car one floor
// per counter period, then holds the door open for one door period.
module elevator_car_fsm
  import elevator_pkg::*;
#(
  parameter int               NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int               FLOOR_W      = FLOOR_W_DEF,
  parameter logic [CNT_W-1:0] TRAVEL_TICKS = TRAVEL_TICKS_DEF,
  parameter logic [CNT_W-1:0] DOOR_TICKS   = DOOR_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  output logic               tmr_start,
  output logic [CNT_W-1:0]   tmr_count,
  input  logic               tmr_finished,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               dir_down,
  output logic               door_open,
  output logic               arrived
);

  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t             state, state_nxt;
  logic [FLOOR_W-1:0] target, target_nxt, cur_nxt, step_floor;
  logic [CNT_W-1:0]   count_nxt;
  logic               ready_nxt, start_nxt, up_nxt, down_nxt, door_nxt, arrived_nxt;
  logic               evt, at_limit;

  timer_event_qual u_qual (
    .clk      (clk),
    .rst      (rst),
    .run      (tmr_start),
    .finished (tmr_finished),
    .evt      (evt)
  );

  assign step_floor = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
  assign at_limit   = !(dir_up || dir_down) || (dir_up && cur_floor == TOP_FLOOR) ||
                      (dir_down && cur_floor == '0);

  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    cur_nxt     = cur_floor;
    ready_nxt   = 1'b0;
    start_nxt   = tmr_start;
    count_nxt   = tmr_count;
    up_nxt      = dir_up;
    down_nxt    = dir_down;
    door_nxt    = door_open;
    arrived_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        start_nxt = 1'b0;
        if (req_valid && req_ready && ({1'b0, req_floor} < FLOOR_LIMIT)) begin
          target_nxt = req_floor;
          ready_nxt  = 1'b0;
          state_nxt  = ST_GAP;
          if (req_floor > cur_floor) begin
            up_nxt    = 1'b1;
            count_nxt = TRAVEL_TICKS;
          end else if (req_floor < cur_floor) begin
            down_nxt  = 1'b1;
            count_nxt = TRAVEL_TICKS;
          end else begin
            count_nxt = DOOR_TICKS;
          end
        end
      end
      // A set direction is the only record of whether travel is still pending.
      ST_GAP: begin
        start_nxt = 1'b1;
        if (dir_up || dir_down) begin
          state_nxt = ST_MOVE;
        end else begin
          state_nxt = ST_DOOR;
          door_nxt  = 1'b1;
        end
      end
      ST_MOVE: begin
        if (evt) begin
          if (at_limit || step_floor == target) begin
            arrived_nxt = !at_limit;
            if (!at_limit)
              cur_nxt = step_floor;
            up_nxt    = 1'b0;
            down_nxt  = 1'b0;
            start_nxt = 1'b0;
            count_nxt = DOOR_TICKS;
            state_nxt = ST_GAP;
          end else begin
            cur_nxt = step_floor;
          end
        end
      end
      ST_DOOR: begin
        if (evt) begin
          door_nxt  = 1'b0;
          start_nxt = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= '0;
      cur_floor <= '0;
      req_ready <= 1'b0;
      tmr_start <= 1'b0;
      tmr_count <= '0;
      dir_up    <= 1'b0;
      dir_down  <= 1'b0;
      door_open <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      cur_floor <= cur_nxt;
      req_ready <= ready_nxt;
      tmr_start <= start_nxt;
      tmr_count <= count_nxt;
      dir_up    <= up_nxt;
      dir_down  <= down_nxt;
      door_open <= door_nxt;
      arrived   <= arrived_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_car_fsm.sv
// Directed bench for elevator_car_fsm with a behavioural tick counter (travel 4, door 6).
module tb_elevator_car_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_floor = 2'd0;
  logic        req_ready, tmr_start, tmr_finished, dir_up, dir_down, door_open, arrived;
  logic [27:0] tmr_count;
  logic [1:0]  cur_floor;
  logic [27:0] cnt;
  logic        fin_cnt;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;

  logic        r3_valid = 1'b0;
  logic [1:0]  r3_floor = 2'd0;
  logic        r3_ready, t3_start, t3_fin, u3, d3, door3, arr3;
  logic [27:0] t3_count, cnt3;
  logic [1:0]  c3_floor;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign tmr_finished = force_en ? force_val : fin_cnt;

  elevator_car_fsm #(.NUM_FLOORS(4), .FLOOR_W(2), .TRAVEL_TICKS(28'd4), .DOOR_TICKS(28'd6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
    .tmr_start(tmr_start), .tmr_count(tmr_count), .tmr_finished(tmr_finished),
    .cur_floor(cur_floor), .dir_up(dir_up), .dir_down(dir_down), .door_open(door_open),
    .arrived(arrived));

  elevator_car_fsm #(.NUM_FLOORS(3), .FLOOR_W(2), .TRAVEL_TICKS(28'd4), .DOOR_TICKS(28'd6)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_floor(r3_floor), .req_ready(r3_ready),
    .tmr_start(t3_start), .tmr_count(t3_count), .tmr_finished(t3_fin),
    .cur_floor(c3_floor), .dir_up(u3), .dir_down(d3), .door_open(door3), .arrived(arr3));

  // Counter: pulses finished once per period while started, holds finished when stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; fin_cnt <= 1'b0;
    end else if (!tmr_start) begin
      cnt <= '0;
    end else if (cnt == tmr_count - 28'd1) begin
      cnt <= '0; fin_cnt <= 1'b1;
    end else begin
      cnt <= cnt + 28'd1; fin_cnt <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt3 <= '0; t3_fin <= 1'b0;
    end else if (!t3_start) begin
      cnt3 <= '0;
    end else if (cnt3 == t3_count - 28'd1) begin
      cnt3 <= '0; t3_fin <= 1'b1;
    end else begin
      cnt3 <= cnt3 + 28'd1; t3_fin <= 1'b0;
    end
  end

  // Presents a request and returns #1 after the accepting edge (the GAP cycle).
  task automatic issue_req(input logic [1:0] fl, input bit hold, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_floor = fl;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Observes a trip from the current cycle until the first IDLE cycle (req_ready high).
  task automatic watch_trip(output int nsteps, output logic [7:0] slog, output int first_step,
                            output int arr_cnt, output logic [1:0] arr_floor, output int door_cyc,
                            output bit up_seen, output bit down_seen, output bit both_seen,
                            output bit tmo);
    logic [1:0] pf;
    pf = cur_floor; nsteps = 0; slog = '0; first_step = -1; arr_cnt = 0; arr_floor = 2'd0;
    door_cyc = 0; up_seen = 0; down_seen = 0; both_seen = 0; tmo = 1;
    for (int c = 0; c < 300; c++) begin
      if (cur_floor !== pf) begin
        if (nsteps < 4) slog[nsteps*2 +: 2] = cur_floor;
        if (nsteps == 0) first_step = c;
        nsteps++;
        pf = cur_floor;
      end
      if (arrived) begin arr_cnt++; arr_floor = cur_floor; end
      if (door_open) door_cyc++;
      if (dir_up) up_seen = 1;
      if (dir_down) down_seen = 1;
      if (dir_up && dir_down) both_seen = 1;
      if (req_ready) begin tmo = 0; break; end
      @(posedge clk); #1;
    end
  endtask

  int ns, fs, ac, dc;
  logic [7:0] sl;
  logic [1:0] af;
  bit us, ds, bs, to, ok;

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({req_ready, tmr_start, tmr_count, cur_floor, dir_up, dir_down, door_open, arrived} !== '0) begin
      failed++; $display("FAIL reset_hold outputs not all zero ready=%b start=%b floor=%0d", req_ready, tmr_start, cur_floor); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
    issue_req(2'd3, 1'b0, ok);
    tests++; if (!ok) begin failed++; $display("FAIL reset_accept request not accepted"); end
    for (int i = 0; i < 60 && cur_floor !== 2'd2; i++) begin @(posedge clk); #1; end
    tests++; if (cur_floor !== 2'd2) begin failed++; $display("FAIL reset_reach2 got floor %0d want 2", cur_floor); end
    #3 rst = 1'b1;
    #1;
    tests++; if ({req_ready, tmr_start, tmr_count, cur_floor, dir_up, dir_down, door_open, arrived} !== '0) begin
      failed++; $display("FAIL reset_async floor=%0d up=%b start=%b count=%0d want all 0", cur_floor, dir_up, tmr_start, tmr_count); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1 || cur_floor !== 2'd0 || tmr_start !== 1'b0) begin
      failed++; $display("FAIL reset_after ready=%b floor=%0d start=%b want 1,0,0", req_ready, cur_floor, tmr_start); end
  endtask

  task automatic test_up();
    issue_req(2'd3, 1'b0, ok);
    tests++; if (!ok || tmr_start !== 1'b0 || tmr_count !== 28'd4 || dir_up !== 1'b1 || req_ready !== 1'b0) begin
      failed++; $display("FAIL up_gap start=%b count=%0d up=%b ready=%b want 0,4,1,0", tmr_start, tmr_count, dir_up, req_ready); end
    @(posedge clk); #1;
    tests++; if (tmr_start !== 1'b1) begin failed++; $display("FAIL up_latency tmr_start got %b want 1", tmr_start); end
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 3 || sl !== 8'h39) begin failed++; $display("FAIL up_steps n=%0d log=%h want 3 39 tmo=%b", ns, sl, to); end
    tests++; if (fs != 5) begin failed++; $display("FAIL up_first_step got cycle %0d want 5", fs); end
    tests++; if (ac != 1 || af !== 2'd3) begin failed++; $display("FAIL up_arrived cnt=%0d floor=%0d want 1,3", ac, af); end
    tests++; if (dc != 7) begin failed++; $display("FAIL up_door got %0d cycles want 7", dc); end
    tests++; if (!us || ds || bs) begin failed++; $display("FAIL up_dirs up=%b down=%b both=%b want 1,0,0", us, ds, bs); end
  endtask

  task automatic test_down();
    issue_req(2'd1, 1'b0, ok);
    tests++; if (!ok || dir_down !== 1'b1 || dir_up !== 1'b0) begin failed++; $display("FAIL down_gap down=%b up=%b want 1,0", dir_down, dir_up); end
    @(posedge clk); #1;
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 2 || sl !== 8'h06 || fs != 5) begin failed++; $display("FAIL down_steps n=%0d log=%h first=%0d want 2 06 5", ns, sl, fs); end
    tests++; if (ac != 1 || af !== 2'd1 || us) begin failed++; $display("FAIL down_arrived cnt=%0d floor=%0d up_seen=%b want 1,1,0", ac, af, us); end
  endtask

  task automatic test_same_floor();
    issue_req(2'd1, 1'b0, ok);
    tests++; if (!ok || tmr_count !== 28'd6 || tmr_start !== 1'b0 || dir_up || dir_down || door_open) begin
      failed++; $display("FAIL same_gap count=%0d start=%b up=%b down=%b door=%b want 6,0,0,0,0", tmr_count, tmr_start, dir_up, dir_down, door_open); end
    @(posedge clk); #1;
    tests++; if (door_open !== 1'b1 || tmr_start !== 1'b1) begin failed++; $display("FAIL same_door door=%b start=%b want 1,1", door_open, tmr_start); end
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 0 || ac != 0 || us || ds || dc != 7) begin
      failed++; $display("FAIL same_trip steps=%0d arrived=%0d up=%b down=%b door=%0d want 0,0,0,0,7", ns, ac, us, ds, dc); end
  endtask

  task automatic test_back_to_back();
    issue_req(2'd2, 1'b1, ok);
    req_floor = 2'd0;
    tests++; if (!ok || req_ready !== 1'b0) begin failed++; $display("FAIL b2b_first ready=%b want 0", req_ready); end
    @(posedge clk); #1;
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 1 || sl !== 8'h02 || af !== 2'd2) begin failed++; $display("FAIL b2b_trip1 n=%0d log=%h arr=%0d want 1 02 2", ns, sl, af); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (req_ready !== 1'b0 || dir_down !== 1'b1 || tmr_count !== 28'd4) begin
      failed++; $display("FAIL b2b_second_accept ready=%b down=%b count=%0d want 0,1,4", req_ready, dir_down, tmr_count); end
    @(posedge clk); #1;
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 2 || sl !== 8'h01 || af !== 2'd0) begin failed++; $display("FAIL b2b_trip2 n=%0d log=%h arr=%0d want 2 01 0", ns, sl, af); end
    // Three-floor car: floor 3 is out of range and must be dropped.
    @(negedge clk); r3_floor = 2'd3; r3_valid = 1'b1;
    tests++; if (r3_ready !== 1'b1) begin failed++; $display("FAIL oor_ready got %b want 1", r3_ready); end
    @(posedge clk); #1; r3_valid = 1'b0;
    us = 0;
    for (int i = 0; i < 10; i++) begin
      if (t3_start || u3 || d3 || c3_floor !== 2'd0 || !r3_ready) us = 1;
      @(posedge clk); #1;
    end
    tests++; if (us) begin failed++; $display("FAIL oor_no_motion motion or stall seen got 1 want 0"); end
    @(negedge clk); r3_floor = 2'd2; r3_valid = 1'b1;
    @(posedge clk); #1; r3_valid = 1'b0;
    tests++; if (u3 !== 1'b1 || r3_ready !== 1'b0) begin failed++; $display("FAIL oor_valid_after up=%b ready=%b want 1,0", u3, r3_ready); end
  endtask

  task automatic test_blanking();
    bit moved;
    force_en = 1'b1; force_val = 1'b1;
    issue_req(2'd1, 1'b0, ok);
    @(posedge clk); #1;
    tests++; if (tmr_start !== 1'b1) begin failed++; $display("FAIL stuck_start got %b want 1", tmr_start); end
    moved = 0;
    for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; if (cur_floor !== 2'd0) moved = 1; end
    tests++; if (moved) begin failed++; $display("FAIL stuck_no_step floor=%0d want 0", cur_floor); end
    force_en = 1'b0;
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 1 || fs != 4 || af !== 2'd1) begin failed++; $display("FAIL stuck_release n=%0d first=%0d arr=%0d want 1,4,1", ns, fs, af); end
    force_en = 1'b1; force_val = 1'b0;
    issue_req(2'd2, 1'b0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    force_val = 1'b1;
    moved = 0;
    for (int k = 2; k <= 9; k++) begin @(posedge clk); #1; if (cur_floor !== 2'd1) moved = 1; end
    tests++; if (moved) begin failed++; $display("FAIL blank_no_step floor=%0d want 1", cur_floor); end
    force_en = 1'b0;
    watch_trip(ns, sl, fs, ac, af, dc, us, ds, bs, to);
    tests++; if (to || ns != 1 || fs != 4 || af !== 2'd2) begin failed++; $display("FAIL blank_release n=%0d first=%0d arr=%0d want 1,4,2", ns, fs, af); end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_same_floor();
    test_back_to_back();
    test_blanking();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
